// File: rtl/hp_reg3_dma.sv
// Parasite-side DMA engine: drains the register-3 host-to-parasite FIFO into
// consecutive parasite memory addresses, in the FIFO's one-byte or two-byte mode.
module hp_reg3_dma #(
  parameter int ADDR_W = 16
) (
  input  logic              p_phi2,
  input  logic              h_rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic              one_byte_mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       byte_count,
  input  logic              p_data_available,
  input  logic              p_two_bytes_available,
  input  logic [7:0]        p_data,
  output logic              p_selectData,
  output logic              p_rdnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_READ0  = 3'd2;
  localparam logic [2:0] S_WRITE0 = 3'd3;
  localparam logic [2:0] S_READ1  = 3'd4;
  localparam logic [2:0] S_WRITE1 = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [15:0]       count_q, count_nxt, count_dec;
  logic [7:0]        wdata_q, wdata_nxt;
  logic              one_byte_q, one_byte_nxt;
  logic              sel_q, we_q, busy_q, done_q;

  // Saturating decrement so the byte counter can never wrap below zero.
  assign count_dec = (count_q != 16'd0) ? count_q - 16'd1 : 16'd0;

  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state_q;
    addr_nxt     = addr_q;
    count_nxt    = count_q;
    wdata_nxt    = wdata_q;
    one_byte_nxt = one_byte_q;

    if (abort && (state_q != S_IDLE)) begin
      // Abort outranks everything, including a write being accepted this edge.
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_nxt     = start_addr;
            count_nxt    = byte_count;
            one_byte_nxt = one_byte_mode;
            state_nxt    = (byte_count == 16'd0) ? S_DONE : S_WAIT;
          end
        end

        S_WAIT: begin
          if (one_byte_q ? p_data_available : p_two_bytes_available)
            state_nxt = S_READ0;
        end

        S_READ0: begin
          wdata_nxt = p_data;
          state_nxt = S_WRITE0;
        end

        S_WRITE0: begin
          if (mem_ready) begin
            addr_nxt  = addr_q + ADDR_W'(1);
            count_nxt = count_dec;
            // Two-byte mode always reads the second byte so the FIFO pair empties.
            if (!one_byte_q)
              state_nxt = S_READ1;
            else if (count_dec == 16'd0)
              state_nxt = S_DONE;
            else
              state_nxt = S_WAIT;
          end
        end

        S_READ1: begin
          // Odd total: the surplus byte is consumed from the FIFO and dropped.
          if (count_q == 16'd0) begin
            state_nxt = S_DONE;
          end else begin
            wdata_nxt = p_data;
            state_nxt = S_WRITE1;
          end
        end

        S_WRITE1: begin
          if (mem_ready) begin
            addr_nxt  = addr_q + ADDR_W'(1);
            count_nxt = count_dec;
            state_nxt = (count_dec == 16'd0) ? S_DONE : S_WAIT;
          end
        end

        S_DONE:  state_nxt = S_IDLE;

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(negedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      one_byte_q <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_nxt;
      count_q    <= count_nxt;
      wdata_q    <= wdata_nxt;
      one_byte_q <= one_byte_nxt;
      // Strobes are decoded from the next state into their own flops so the
      // outputs come straight from registers.
      sel_q      <= (state_nxt == S_READ0)  || (state_nxt == S_READ1);
      we_q       <= (state_nxt == S_WRITE0) || (state_nxt == S_WRITE1);
      busy_q     <= (state_nxt != S_IDLE)   && (state_nxt != S_DONE);
      done_q     <= (state_nxt == S_DONE);
    end
  end

  assign p_selectData = sel_q;
  assign p_rdnw       = 1'b1;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = we_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_hp_reg3_dma.sv
// Directed bench for hp_reg3_dma: a FIFO/memory model checks every accepted
// write against an expected-write list and checks bus rules every cycle.
module tb_hp_reg3_dma;

  logic        p_phi2 = 1'b0;
  logic        h_rst_b;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        one_byte_mode = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] byte_count = '0;
  logic        p_data_available = 1'b0;
  logic        p_two_bytes_available = 1'b0;
  logic [7:0]  p_data = '0;
  logic        p_selectData, p_rdnw, mem_we, busy, done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b1;

  hp_reg3_dma #(.ADDR_W(16)) dut (
    .p_phi2(p_phi2), .h_rst_b(h_rst_b), .start(start), .abort(abort),
    .one_byte_mode(one_byte_mode), .start_addr(start_addr), .byte_count(byte_count),
    .p_data_available(p_data_available), .p_two_bytes_available(p_two_bytes_available),
    .p_data(p_data), .p_selectData(p_selectData), .p_rdnw(p_rdnw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  always #5 p_phi2 = ~p_phi2;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fifo_q[$];
  wr_t        e_wr;

  int n_checks = 0, n_pass = 0;
  int reads = 0, writes = 0, done_cnt = 0, stall_cycles = 0, stall_left = 0;
  bit pop_pending = 1'b0, two_gate = 1'b1, prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  int r0, w0, d0, s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO + memory model and per-cycle compare, running just after the
  // non-active (rising) edge so DUT outputs and bench inputs are settled.
  always begin
    @(posedge p_phi2);
    #1;
    if (pop_pending) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
    end
    p_data                = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    p_data_available      = (fifo_q.size() > 0);
    p_two_bytes_available = two_gate && (fifo_q.size() > 1);
    if (mem_we && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
      stall_cycles++;
    end else begin
      mem_ready = 1'b1;
    end
    if (h_rst_b) begin
      check("rdnw_high", 32'(p_rdnw), 32'd1);
      check("done_excl_busy", 32'(done & busy), 32'd0);
      check("we_excl_sel", 32'(mem_we & p_selectData), 32'd0);
      check("activity_needs_busy", 32'((mem_we | p_selectData) & ~busy), 32'd0);
      if (prev_stall && mem_we) begin
        check("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("stall_data_stable", 32'(mem_wdata), 32'(prev_data));
      end
      if (mem_we && mem_ready && !abort) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e_wr = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e_wr.addr));
          check("wr_data", 32'(mem_wdata), 32'(e_wr.data));
        end
      end
      if (p_selectData) begin
        reads++;
        pop_pending = 1'b1;
      end
      if (done) done_cnt++;
    end
    prev_stall = h_rst_b && mem_we && !mem_ready;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge p_phi2);
  endtask

  task automatic start_xfer(input logic [15:0] a, input logic [15:0] c, input logic m);
    @(posedge p_phi2);
    start_addr    = a;
    byte_count    = c;
    one_byte_mode = m;
    start         = 1'b1;
    @(posedge p_phi2);
    start = 1'b0;
  endtask

  task automatic wait_we(input string name, input int budget);
    int k = 0;
    while (!mem_we && k < budget) begin
      @(posedge p_phi2);
      k++;
    end
    check(name, 32'(mem_we), 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(posedge p_phi2);
      k++;
    end
    check(name, 32'(done), 32'd1);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic snap();
    r0 = reads; w0 = writes; d0 = done_cnt; s0 = stall_cycles;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset values
    h_rst_b = 1'b1;
    #1 h_rst_b = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel", 32'(p_selectData), 32'd0);
    check("rst_rdnw", 32'(p_rdnw), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    tick(2);
    h_rst_b = 1'b1;
    tick(2);

    // Reset while a write is pending in WRITE0
    fifo_q.push_back(8'h55);
    exp_q.push_back('{addr: 16'h1234, data: 8'h55});
    stall_left = 1000;
    start_xfer(16'h1234, 16'd2, 1'b1);
    wait_we("t1_reach_write", 20);
    #3 h_rst_b = 1'b0;
    #1;
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_sel", 32'(p_selectData), 32'd0);
    check("t1_rdnw", 32'(p_rdnw), 32'd1);
    check("t1_we", 32'(mem_we), 32'd0);
    check("t1_addr", 32'(mem_addr), 32'd0);
    check("t1_wdata", 32'(mem_wdata), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    pop_pending = 1'b0;
    stall_left  = 0;
    @(posedge p_phi2);
    h_rst_b = 1'b1;
    tick(2);
    check("t1_idle_after_release", 32'(busy | mem_we | p_selectData), 32'd0);

    // One-byte mode, three bytes, memory always ready
    fifo_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_q.push_back('{addr: 16'h1000, data: 8'hA1});
    exp_q.push_back('{addr: 16'h1001, data: 8'hA2});
    exp_q.push_back('{addr: 16'h1002, data: 8'hA3});
    tick(1);
    snap();
    start_xfer(16'h1000, 16'd3, 1'b1);
    check("t2_busy_after_start", 32'(busy), 32'd1);
    check("t2_addr_after_start", 32'(mem_addr), 32'h1000);
    check("t2_wait_no_sel", 32'(p_selectData), 32'd0);
    @(posedge p_phi2);
    check("t2_read0_sel", 32'(p_selectData), 32'd1);
    @(posedge p_phi2);
    check("t2_write0_we", 32'(mem_we), 32'd1);
    check("t2_write0_data", 32'(mem_wdata), 32'hA1);
    wait_done("t2_done", 40);
    @(posedge p_phi2);
    check("t2_done_one_cycle", 32'(done), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);
    tick(2);
    check("t2_reads", 32'(reads - r0), 32'd3);
    check("t2_writes", 32'(writes - w0), 32'd3);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t2_exp_left", 32'(exp_q.size()), 32'd0);

    // Two-byte mode ignores the single-byte flag
    two_gate = 1'b0;
    fifo_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_q.push_back('{addr: 16'h4000, data: 8'hB1});
    exp_q.push_back('{addr: 16'h4001, data: 8'hB2});
    exp_q.push_back('{addr: 16'h4002, data: 8'hB3});
    exp_q.push_back('{addr: 16'h4003, data: 8'hB4});
    tick(1);
    snap();
    start_xfer(16'h4000, 16'd4, 1'b0);
    check("t3_single_flag_up", 32'(p_data_available), 32'd1);
    tick(10);
    check("t3_no_reads_gated", 32'(reads - r0), 32'd0);
    check("t3_still_busy", 32'(busy), 32'd1);
    two_gate = 1'b1;
    wait_done("t3_done", 60);
    tick(2);
    check("t3_reads", 32'(reads - r0), 32'd4);
    check("t3_writes", 32'(writes - w0), 32'd4);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t3_exp_left", 32'(exp_q.size()), 32'd0);

    // Two-byte mode, odd count: last pair read, second byte dropped
    fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    exp_q.push_back('{addr: 16'h2000, data: 8'hC1});
    exp_q.push_back('{addr: 16'h2001, data: 8'hC2});
    exp_q.push_back('{addr: 16'h2002, data: 8'hC3});
    tick(1);
    snap();
    start_xfer(16'h2000, 16'd3, 1'b0);
    wait_done("t4_done", 60);
    tick(2);
    check("t4_reads", 32'(reads - r0), 32'd4);
    check("t4_writes", 32'(writes - w0), 32'd3);
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t4_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("t4_exp_left", 32'(exp_q.size()), 32'd0);

    // Address wrap with a five-cycle stall on the first write
    fifo_q = '{8'hD1, 8'hD2};
    exp_q.push_back('{addr: 16'hFFFF, data: 8'hD1});
    exp_q.push_back('{addr: 16'h0000, data: 8'hD2});
    stall_left = 5;
    tick(1);
    snap();
    start_xfer(16'hFFFF, 16'd2, 1'b1);
    wait_done("t5_done", 60);
    check("t5_final_addr", 32'(mem_addr), 32'h0001);
    tick(2);
    check("t5_stall_cycles", 32'(stall_cycles - s0), 32'd5);
    check("t5_writes", 32'(writes - w0), 32'd2);
    check("t5_exp_left", 32'(exp_q.size()), 32'd0);

    // Abort in WAIT, start while busy, then a zero-length transfer
    snap();
    start_xfer(16'h2800, 16'd5, 1'b1);
    tick(2);
    check("t6_busy_waiting", 32'(busy), 32'd1);
    start_xfer(16'h5555, 16'd9, 1'b1);
    check("t6_busy_start_ignored", 32'(mem_addr), 32'h2800);
    @(posedge p_phi2);
    abort = 1'b1;
    @(posedge p_phi2);
    abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_done", 32'(done), 32'd0);
    check("t6_abort_strobes", 32'(mem_we | p_selectData), 32'd0);
    tick(3);
    check("t6_abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_abort_addr_kept", 32'(mem_addr), 32'h2800);
    start_xfer(16'h3000, 16'd0, 1'b1);
    check("t6_zero_done", 32'(done), 32'd1);
    check("t6_zero_busy", 32'(busy), 32'd0);
    check("t6_zero_addr", 32'(mem_addr), 32'h3000);
    @(posedge p_phi2);
    check("t6_zero_done_drop", 32'(done), 32'd0);
    tick(2);
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t6_reads", 32'(reads - r0), 32'd0);
    check("t6_writes", 32'(writes - w0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
